// File: rtl/decoder_port_arbiter_if.sv
//------------------------------------------------------------------------------
// decoder_port_arbiter_if : request/flit/decoder bundle for decoder_port_arbiter
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

interface decoder_port_arbiter_if #(
   parameter int NUM_PORTS  = 4,
   parameter int FLIT_WIDTH = 16
);
   localparam int GW = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]              req_valid;
   logic [NUM_PORTS*6*FLIT_WIDTH-1:0] req_flits;
   logic [NUM_PORTS-1:0]              req_ack;
   logic                              req_err;
   logic                              dec_en;
   logic [FLIT_WIDTH-1:0]             dec_head_flit;
   logic [FLIT_WIDTH-1:0]             dec_body_flit_1;
   logic [FLIT_WIDTH-1:0]             dec_body_flit_2;
   logic [FLIT_WIDTH-1:0]             dec_body_flit_3;
   logic [FLIT_WIDTH-1:0]             dec_body_flit_4;
   logic [FLIT_WIDTH-1:0]             dec_tail_flit;
   logic                              dec_done;
   logic [GW-1:0]                     grant_id;
   logic                              busy;

   // master: the arbiter itself; slave: requesters plus decoder environment
   modport master (
      input  req_valid, req_flits, dec_done,
      output req_ack, req_err, dec_en, grant_id, busy,
      output dec_head_flit, dec_body_flit_1, dec_body_flit_2,
      output dec_body_flit_3, dec_body_flit_4, dec_tail_flit
   );

   modport slave (
      output req_valid, req_flits, dec_done,
      input  req_ack, req_err, dec_en, grant_id, busy,
      input  dec_head_flit, dec_body_flit_1, dec_body_flit_2,
      input  dec_body_flit_3, dec_body_flit_4, dec_tail_flit
   );
endinterface

`default_nettype wire

// File: rtl/decoder_port_arbiter.sv
//------------------------------------------------------------------------------
// decoder_port_arbiter : round-robin sharing of one packet decoder among ports
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module decoder_port_arbiter #(
   parameter int NUM_PORTS      = 4,
   parameter int FLIT_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   decoder_port_arbiter_if.master bus
);
   localparam int GW = $clog2(NUM_PORTS);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW = 6 * FLIT_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LAUNCH  = 2'd1,
      S_WAIT    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t                state_q;
   logic [GW-1:0]         ptr_q;
   logic [GW-1:0]         grant_q;
   logic [CW-1:0]         cnt_q;
   logic [NUM_PORTS-1:0]  ack_q;
   logic                  err_q;
   logic                  en_q;
   logic                  busy_q;
   logic [PW-1:0]         flits_q;

   logic                  found_d;
   logic [GW-1:0]         win_d;
   logic [GW-1:0]         cand_d;
   logic [GW-1:0]         ptr_d;
   int                    idx_d;

   // Search upward from ptr_q with wrap; first requesting port wins.
   always_comb begin
      found_d = 1'b0;
      win_d   = '0;
      cand_d  = '0;
      idx_d   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx_d = int'(ptr_q) + i;
         if (idx_d >= NUM_PORTS) begin
            idx_d = idx_d - NUM_PORTS;
         end
         cand_d = GW'(idx_d);
         if (!found_d && bus.req_valid[cand_d]) begin
            found_d = 1'b1;
            win_d   = cand_d;
         end
      end
      ptr_d = (win_d == GW'(NUM_PORTS - 1)) ? '0 : win_d + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         flits_q <= '0;
      end else begin
         en_q  <= 1'b0;
         ack_q <= '0;
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A decoder still driving its previous result blocks any grant.
               if (found_d && !bus.dec_done) begin
                  grant_q <= win_d;
                  flits_q <= bus.req_flits[win_d*PW +: PW];
                  ptr_q   <= ptr_d;
                  en_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.dec_done) begin
                  ack_q[grant_q] <= 1'b1;
                  state_q        <= S_RELEASE;
               end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  ack_q[grant_q] <= 1'b1;
                  err_q          <= 1'b1;
                  state_q        <= S_RELEASE;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RELEASE: begin
               if (!bus.dec_done) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ack         = ack_q;
   assign bus.req_err         = err_q;
   assign bus.dec_en          = en_q;
   assign bus.grant_id        = grant_q;
   assign bus.busy            = busy_q;
   assign bus.dec_head_flit   = flits_q[0*FLIT_WIDTH +: FLIT_WIDTH];
   assign bus.dec_body_flit_1 = flits_q[1*FLIT_WIDTH +: FLIT_WIDTH];
   assign bus.dec_body_flit_2 = flits_q[2*FLIT_WIDTH +: FLIT_WIDTH];
   assign bus.dec_body_flit_3 = flits_q[3*FLIT_WIDTH +: FLIT_WIDTH];
   assign bus.dec_body_flit_4 = flits_q[4*FLIT_WIDTH +: FLIT_WIDTH];
   assign bus.dec_tail_flit   = flits_q[5*FLIT_WIDTH +: FLIT_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_decoder_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_decoder_port_arbiter : directed self-checking bench for decoder_port_arbiter
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decoder_port_arbiter;
   localparam int NP = 4;
   localparam int FW = 16;
   localparam int TO = 15;
   localparam int PW = 6 * FW;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_mis;

   decoder_port_arbiter_if #(.NUM_PORTS(NP), .FLIT_WIDTH(FW)) bus ();

   decoder_port_arbiter #(
      .NUM_PORTS      (NP),
      .FLIT_WIDTH     (FW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Called in an IDLE cycle with the winning request already presented;
   // decoder raises dec_done in cycle 4 and drops it in cycle 5.
   task automatic txn(input logic [1:0] port);
      tick();
      check("launch_en", bus.dec_en, 1);
      check("launch_gid", bus.grant_id, port);
      check("launch_busy", bus.busy, 1);
      tick();
      check("wait_en_low", bus.dec_en, 0);
      tick();
      tick();
      bus.dec_done = 1'b1;
      check("no_early_ack", bus.req_ack, 0);
      tick();
      check("ack_onehot", bus.req_ack, 32'd1 << port);
      check("ack_no_err", bus.req_err, 0);
      bus.dec_done = 1'b0;
      tick();
      check("idle_ack_clr", bus.req_ack, 0);
      check("idle_busy", bus.busy, 0);
   endtask

   initial begin
      n_cmp         = 0;
      n_mis         = 0;
      rst           = 1'b0;
      bus.req_valid = '0;
      bus.req_flits = '0;
      bus.dec_done  = 1'b0;

      // Reset state
      do_reset();
      check("rst_ack", bus.req_ack, 0);
      check("rst_err", bus.req_err, 0);
      check("rst_en", bus.dec_en, 0);
      check("rst_gid", bus.grant_id, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_head", bus.dec_head_flit, 0);
      check("rst_tail", bus.dec_tail_flit, 0);

      // Single request on port 2, flits changed mid-transaction must not leak
      bus.req_flits[2*PW +: PW] = {16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000};
      bus.req_valid = 4'b0100;
      tick();
      check("s_en", bus.dec_en, 1);
      check("s_gid", bus.grant_id, 2);
      check("s_head", bus.dec_head_flit, 16'h1000);
      check("s_tail", bus.dec_tail_flit, 16'h1005);
      bus.req_flits[2*PW +: PW] = {6{16'hDEAD}};
      tick();
      check("s_en_pulse", bus.dec_en, 0);
      tick();
      tick();
      bus.dec_done = 1'b1;
      tick();
      check("s_ack", bus.req_ack, 4'b0100);
      check("s_err", bus.req_err, 0);
      check("s_b1", bus.dec_body_flit_1, 16'h1001);
      check("s_b2", bus.dec_body_flit_2, 16'h1002);
      check("s_b3", bus.dec_body_flit_3, 16'h1003);
      check("s_b4", bus.dec_body_flit_4, 16'h1004);
      check("s_tail_hold", bus.dec_tail_flit, 16'h1005);
      bus.dec_done = 1'b0;
      tick();
      bus.req_valid = '0;
      check("s_ack_pulse", bus.req_ack, 0);
      check("s_busy_fall", bus.busy, 0);
      tick();
      check("s_no_regrant", bus.dec_en, 0);

      // Fairness from a fresh pointer, then wrap with only ports 3 and 0
      do_reset();
      bus.req_valid = 4'b1111;
      txn(2'd0);
      txn(2'd1);
      txn(2'd2);
      txn(2'd3);
      txn(2'd0);
      txn(2'd1);
      txn(2'd2);
      txn(2'd3);
      bus.req_valid = 4'b1001;
      txn(2'd0);
      txn(2'd3);
      bus.req_valid = '0;

      // Timeout with a silent decoder
      do_reset();
      bus.req_valid = 4'b0010;
      tick();
      check("to_en", bus.dec_en, 1);
      for (int c = 2; c <= 16; c++) begin
         tick();
      end
      check("to_no_ack16", bus.req_ack, 0);
      tick();
      check("to_ack17", bus.req_ack, 4'b0010);
      check("to_err17", bus.req_err, 1);
      check("to_busy17", bus.busy, 1);
      tick();
      bus.req_valid = '0;
      check("to_ack_clr", bus.req_ack, 0);
      check("to_err_clr", bus.req_err, 0);
      check("to_idle", bus.busy, 0);

      // Busy decoder holds off the grant
      do_reset();
      bus.dec_done  = 1'b1;
      bus.req_valid = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bz_no_en", bus.dec_en, 0);
         check("bz_no_busy", bus.busy, 0);
      end
      bus.dec_done = 1'b0;
      txn(2'd1);
      bus.req_valid = '0;

      // Reset in WAIT_DONE: pointer is 2 here, so port 3 wins first
      bus.req_valid = 4'b1010;
      tick();
      check("mr_gid", bus.grant_id, 3);
      tick();
      rst = 1'b1;
      #1;
      check("mr_ack", bus.req_ack, 0);
      check("mr_err", bus.req_err, 0);
      check("mr_busy", bus.busy, 0);
      check("mr_gid0", bus.grant_id, 0);
      check("mr_head0", bus.dec_head_flit, 0);
      tick();
      check("mr_hold_ack", bus.req_ack, 0);
      rst = 1'b0;
      txn(2'd1);
      bus.req_valid = '0;
      tick();
      check("end_idle", bus.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/decoder_port_arbiter.md
# decoder_port_arbiter

Round-robin arbiter and sequencer that shares the single packet decoder between several NoC input ports. Each port presents a complete six-flit packet (head, four body, tail) with a valid/ack handshake. The block grants one port, holds that packet's flits stable on the decoder inputs, and pulses the decoder enable. It then waits for the decoder's drive phase (or a timeout) and acknowledges the requester before serving the next port.

## Interface
- NUM_PORTS, 4: number of requesting ports (2..8).
- FLIT_WIDTH, 16: bits per flit.
- TIMEOUT_CYCLES, 15: maximum cycles spent in WAIT_DONE before aborting (≥1).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_PORTS  per-port packet-present request.
- req_flits  in  NUM_PORTS*6*FLIT_WIDTH  packed flits. Port p occupies slice [p*6*FLIT_WIDTH +: 6*FLIT_WIDTH], ordered head (lsb), body1..body4, tail (msb).
- req_ack  out  NUM_PORTS  one-cycle completion pulse to the granted port.
- req_err  out  1  one-cycle pulse coincident with req_ack when the transaction timed out.
- dec_en  out  1  one-cycle start pulse to the decoder.
- dec_head_flit, dec_body_flit_1..4, dec_tail_flit  out  FLIT_WIDTH each  registered flits driven to the decoder.
- dec_done  in  1  decoder output-enable; high while the decoder is in its drive phase.
- grant_id  out  clog2(NUM_PORTS)  index of the current/last granted port.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, RELEASE.
- Round-robin pointer `ptr` resets to 0. In IDLE, the block searches req_valid starting at `ptr` and wrapping upward. The first set bit k wins.
- IDLE → LAUNCH when any req_valid is set and dec_done=0. If dec_done=1 in IDLE (decoder still finishing), the block does not grant. In the grant cycle:
  - grant_id←k
  - all six dec_* flit registers←port k slice
  - ptr←(k+1) mod NUM_PORTS
- LAUNCH: dec_en=1 for exactly this cycle. Go to WAIT_DONE. Timeout counter clears to 0.
- WAIT_DONE:
  - If dec_done=1: req_ack[grant_id]←1 (registered, visible next cycle), req_err←0, go to RELEASE.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 and dec_done is still 0: req_ack[grant_id]←1, req_err←1, go to RELEASE.
  - Counter width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- RELEASE: wait for dec_done=0, then go to IDLE. Ack/err pulses last exactly one cycle.
- Flit registers hold their value from grant until the next grant. They do not change during a transaction even if the requester's inputs change.
- A requester deasserting req_valid after grant does not cancel the transaction; ack is still issued. A requester must keep req_valid high until ack and drop it the cycle after. A port whose valid is still high in IDLE after its ack is treated as a new packet.
- Only one port is served at a time. req_ack is one-hot or zero.
- Reset mid-transaction: all state returns to reset immediately. No ack or err is issued for the aborted packet, and ptr returns to 0.

## Timing
- Reset values:
  - 0: req_ack, req_err, dec_en, all dec_* flits, grant_id, busy, ptr, counter.
  - State = IDLE.
- With a decoder that raises dec_done 3 cycles after sampling dec_en:
  - cycle 0: IDLE, valid seen
  - cycle 1: dec_en=1
  - cycles 2–3: decoder sample/decode
  - cycle 4: dec_done=1
  - cycle 5: req_ack=1, state RELEASE, dec_done=0
  - cycle 6: IDLE
  - cycle 7: earliest dec_en for the next packet
- Grant-to-ack latency is 5 cycles nominal. A timeout gives req_ack at cycle 2+TIMEOUT_CYCLES.
- busy rises the cycle after grant and falls in the cycle the FSM re-enters IDLE.

## Test plan
- Single request: port 2 valid, flits 0x1000..0x1005 → dec_en one pulse at cycle 1, dec_head_flit=0x1000 … dec_tail_flit=0x1005 stable through RELEASE, req_ack=4'b0100 at cycle 5, req_err=0.
- Fairness: all four ports continuously valid → grant order 0,1,2,3,0,1. Each port acked exactly once per round, and no two acks overlap.
- Wrap: after port 3 is served, only ports 3 and 0 valid → port 0 granted next (ptr wrapped to 0).
- Timeout: dec_done tied 0, TIMEOUT_CYCLES=15 → req_ack and req_err both pulse for one cycle at cycle 17, then state returns to IDLE.
- Busy decoder: dec_done held 1 in IDLE with port 1 valid → no dec_en until dec_done falls. Grant then occurs the cycle dec_done=0.
- Reset mid-transaction: assert rst in WAIT_DONE → all outputs 0 immediately, no ack. The next grant after reset starts search from port 0.
